branch_predictor: RTL and testbench
===================================

// Module: branch_predictor
// PURPOSE
//  - Fetch-side counterpart of the branch-resolution AND gate: predicts beq outcome at fetch
//    using a table of 2-bit saturating counters indexed by PC.
//  - Trains on resolved outcome (branch & zero) written back from execute.
//  - Sits beside the PC register; predict_taken steers the early next-PC mux.
// PARAMETERS
//  - IDX_BITS  6   log2 of table entries (64 entries)
//  - PC_W      32  PC width in bits
// PORTS
//  - clk             in   1         single clock, rising edge
//  - rst             in   1         synchronous, active-high reset
//  - lookup_valid    in   1         fetch requests a prediction this cycle
//  - lookup_pc       in   PC_W      PC of the fetched instruction
//  - predict_valid   out  1         prediction available (1 cycle after lookup_valid)
//  - predict_taken   out  1         predicted direction, qualified by predict_valid
//  - update_valid    in   1         execute resolved a branch this cycle
//  - update_pc       in   PC_W      PC of the resolved branch
//  - update_taken    in   1         resolved outcome (branch & zero)
//  - mispredict_cnt  out  16        stats only (BRANCH_PRED_STATS_EN), else tied 0
// BEHAVIOUR
//  - Index = pc[IDX_BITS+1:2]; word-aligned PC, bits [1:0] ignored; no tags, aliasing allowed.
//  - Counter states: SNT=00, WNT=01, WT=10, ST=11. Predict taken iff counter[1]==1.
//  - Lookup: registered, latency 1. lookup_valid at cycle N -> predict_valid/predict_taken
//    at N+1. predict_valid low in any cycle after lookup_valid was low;
//    predict_taken holds 0 when predict_valid is 0.
//  - Update: on update_valid at cycle N, counter at update index becomes visible from N+1.
//    taken: increment, saturate at ST. not taken: decrement, saturate at SNT.
//  - Same-cycle lookup and update to the same index: lookup returns the PRE-update
//    counter (read-before-write). Update still applied. No stall, no backpressure.
//  - Both ports are accepted every cycle; there is no ready signal.
//  - Reset: all counters -> WNT (01); predict_valid=0; predict_taken=0; mispredict_cnt=0.
//    rst overrides any same-cycle lookup/update. Pending prediction is dropped.
//  - X on lookup_pc while lookup_valid=0 has no effect on state.
// CONFIGURATION
//  - Macro BRANCH_PRED_STATS_EN.
//    Defined: 16-bit mispredict_cnt increments on update_valid when pre-update
//    counter[1] != update_taken. Saturates at 16'hFFFF. Cleared by rst.
//    Undefined: mispredict_cnt tied to 16'h0, no counter flops.
//  - Port list identical in both builds.
// STRUCTURE
//  - Package bp_pkg:
//    - typedef of 2-bit counter type
//    - constants SNT/WNT/WT/ST and CNT_RESET=WNT
//    - function bp_index(pc)
//  - Sub-module branch_pred_counter: combinational next-state (cur, taken) -> nxt,
//    saturating. Shared by the update path; unit-testable alone.
//  - Table = flop array, 2^IDX_BITS x 2 bits, synchronously reset. No SRAM.
// TESTING
//  - Reset then lookup pc=0x0040_0000 -> predict_valid=1, predict_taken=0 next cycle (WNT).
//  - Two updates taken at pc=0x0040_0010, then lookup -> taken (ST).
//    Third taken update keeps ST; one not-taken update still predicts taken (WT).
//  - Three not-taken updates at pc=0x10 from WNT -> SNT, saturates, predict_taken=0.
//  - Same-cycle lookup+update taken at pc=0x20 from WNT -> prediction 0, following
//    lookup -> 1.
//  - Aliasing: update taken x2 at pc=0x0 -> lookup pc=0x100 (IDX_BITS=6) predicts taken;
//    pc=0x4 unaffected (not taken).
//  - BRANCH_PRED_STATS_EN: 3 updates taken,taken,not-taken at pc=0x30 from WNT ->
//    mispredict_cnt=2. Assert rst mid-stream -> all outputs 0 and table back to WNT
//    on next cycle.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// The 2-bit counter encoding is fixed: SNT=00, WNT=01, WT=10, ST=11.
package bp_pkg;

   typedef logic [1:0] cnt_t;

   localparam cnt_t SNT       = 2'b00;
   localparam cnt_t WNT       = 2'b01;
   localparam cnt_t WT        = 2'b10;
   localparam cnt_t ST        = 2'b11;
   localparam cnt_t CNT_RESET = WNT;

   // Table index from a word-aligned PC: drop pc[1:0] and keep the next idx_bits bits.
   // The PC is passed zero-extended to 64 bits so the helper serves any PC width.
   function automatic logic [31:0] bp_index(input logic [63:0] pc, input int unsigned idx_bits);
      logic [63:0] mask;
      mask = (64'd1 << idx_bits) - 64'd1;
      return 32'((pc >> 2) & mask);
   endfunction

endpackage

// File: rtl/branch_pred_counter.sv
// Saturating 2-bit counter next-state logic: taken counts up to ST,
// not-taken counts down to SNT. Purely combinational.
module branch_pred_counter
   import bp_pkg::*;
(
   input  cnt_t cur,
   input  logic taken,
   output cnt_t nxt
);

   // Next counter value, holding at the ends instead of wrapping.
   always_comb begin
      // NOTE: default assigned first so every path drives nxt and no latch is inferred.
      nxt = cur;
      if (taken) begin
         if (cur != ST) nxt = cur + 2'd1;
      end else begin
         if (cur != SNT) nxt = cur - 2'd1;
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: a flop table of 2-bit saturating counters indexed by PC.
// Lookup is registered (result one cycle later, read-before-write against a
// same-cycle update). Updates train the counter at the resolved branch's index.
// Optional build macro BRANCH_PRED_STATS_EN adds a saturating mispredict counter;
// without it mispredict_cnt is tied to zero.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int IDX_BITS = 6,
   parameter int PC_W     = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            lookup_valid,
   input  logic [PC_W-1:0] lookup_pc,
   output logic            predict_valid,
   output logic            predict_taken,
   input  logic            update_valid,
   input  logic [PC_W-1:0] update_pc,
   input  logic            update_taken,
   output logic [15:0]     mispredict_cnt
);

   localparam int ENTRIES = 1 << IDX_BITS;

   logic [IDX_BITS-1:0] lookup_idx;
   logic [IDX_BITS-1:0] update_idx;
   cnt_t                cnt_table [ENTRIES];
   cnt_t                upd_cur;
   cnt_t                upd_nxt;

   assign lookup_idx = IDX_BITS'(bp_index(64'(lookup_pc), IDX_BITS));
   assign update_idx = IDX_BITS'(bp_index(64'(update_pc), IDX_BITS));
   assign upd_cur    = cnt_table[update_idx];

   branch_pred_counter u_counter (
      .cur   (upd_cur),
      .taken (update_taken),
      .nxt   (upd_nxt)
   );

   // Counter table: reset every entry to weakly-not-taken, then train on resolved branches.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: this table is a flop array, not an SRAM, so a full reset is legal and
         // gives a known starting prediction; an SRAM-backed table could not be reset this way.
         for (int i = 0; i < ENTRIES; i++) begin
            cnt_table[i] <= CNT_RESET;
         end
      end else if (update_valid) begin
         cnt_table[update_idx] <= upd_nxt;
      end
   end

   // Registered lookup; sees the table before any same-cycle update lands.
   always_ff @(posedge clk) begin
      if (rst) begin
         predict_valid <= 1'b0;
         predict_taken <= 1'b0;
      end else begin
         // NOTE: non-blocking assignment samples cnt_table before this edge's update,
         // which is exactly the read-before-write ordering wanted here.
         predict_valid <= lookup_valid;
         if (lookup_valid) begin
            predict_taken <= cnt_table[lookup_idx][1];
         end else begin
            predict_taken <= 1'b0;
         end
      end
   end

`ifdef BRANCH_PRED_STATS_EN
   logic [15:0] miss_q;

   // Count updates whose pre-update prediction disagreed with the outcome, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         miss_q <= 16'h0;
      end else if (update_valid && (upd_cur[1] != update_taken) && (miss_q != 16'hFFFF)) begin
         miss_q <= miss_q + 16'd1;
      end
   end

   assign mispredict_cnt = miss_q;
`else
   assign mispredict_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor: a vector table for the
// single-cycle behaviour plus hand-written sequences for stats and mid-stream reset.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        rst;
   logic        lookup_valid;
   logic [31:0] lookup_pc;
   logic        predict_valid;
   logic        predict_taken;
   logic        update_valid;
   logic [31:0] update_pc;
   logic        update_taken;
   logic [15:0] mispredict_cnt;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic        rst;
      logic        lv;
      logic [31:0] lpc;
      logic        uv;
      logic [31:0] upc;
      logic        ut;
      logic        exp_valid;
      logic        exp_taken;
   } vec_t;

   vec_t vecs[$];

   branch_predictor #(.IDX_BITS(6), .PC_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .lookup_valid   (lookup_valid),
      .lookup_pc      (lookup_pc),
      .predict_valid  (predict_valid),
      .predict_taken  (predict_taken),
      .update_valid   (update_valid),
      .update_pc      (update_pc),
      .update_taken   (update_taken),
      .mispredict_cnt (mispredict_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   task automatic add(input string name, input logic r, input logic lv, input logic [31:0] lpc,
                      input logic uv, input logic [31:0] upc, input logic ut,
                      input logic ev, input logic et);
      vec_t v;
      v.name = name; v.rst = r; v.lv = lv; v.lpc = lpc;
      v.uv = uv; v.upc = upc; v.ut = ut; v.exp_valid = ev; v.exp_taken = et;
      vecs.push_back(v);
   endtask

   // Drive one cycle of inputs on the falling edge; outputs settle after the next rising edge.
   task automatic drive(input logic r, input logic lv, input logic [31:0] lpc,
                        input logic uv, input logic [31:0] upc, input logic ut);
      @(negedge clk);
      rst = r; lookup_valid = lv; lookup_pc = lpc;
      update_valid = uv; update_pc = upc; update_taken = ut;
      @(posedge clk);
      #1;
   endtask

   logic [15:0] exp_stats;

   initial begin
      rst = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
      update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;

      // Reset state
      drive(1, 0, 0, 0, 0, 0);
      drive(1, 1, 32'h0040_0000, 1, 32'h0040_0000, 1);
      check("reset_valid", {31'd0, predict_valid}, 0);
      check("reset_taken", {31'd0, predict_taken}, 0);
      check("reset_stats", {16'd0, mispredict_cnt}, 0);

      //   name              rst lv lpc            uv upc            ut ev et
      add("lookup_wnt",      0, 1, 32'h0040_0000, 0, 0,             0, 1, 0);
      add("idle",            0, 0, 0,             0, 0,             0, 0, 0);
      add("upd_t1",          0, 0, 0,             1, 32'h0040_0010, 1, 0, 0);
      add("upd_t2",          0, 0, 0,             1, 32'h0040_0010, 1, 0, 0);
      add("lookup_st",       0, 1, 32'h0040_0010, 0, 0,             0, 1, 1);
      add("upd_t3_lookup",   0, 1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 1);
      add("upd_nt",          0, 0, 0,             1, 32'h0040_0010, 0, 0, 0);
      add("lookup_wt",       0, 1, 32'h0040_0010, 0, 0,             0, 1, 1);
      add("rst_mid",         1, 1, 32'h0040_0010, 0, 0,             0, 0, 0);
      add("upd_nt1",         0, 0, 0,             1, 32'h10,        0, 0, 0);
      add("upd_nt2",         0, 0, 0,             1, 32'h10,        0, 0, 0);
      add("upd_nt3",         0, 0, 0,             1, 32'h10,        0, 0, 0);
      add("lookup_snt",      0, 1, 32'h10,        0, 0,             0, 1, 0);
      add("snt_up1",         0, 0, 0,             1, 32'h10,        1, 0, 0);
      add("lookup_after_up1",0, 1, 32'h10,        0, 0,             0, 1, 0);
      add("snt_up2",         0, 0, 0,             1, 32'h10,        1, 0, 0);
      add("lookup_after_up2",0, 1, 32'h10,        0, 0,             0, 1, 1);
      add("rbw_same_cycle",  0, 1, 32'h20,        1, 32'h20,        1, 1, 0);
      add("rbw_following",   0, 1, 32'h20,        0, 0,             0, 1, 1);
      add("alias_upd1",      0, 0, 0,             1, 32'h0,         1, 0, 0);
      add("alias_upd2",      0, 0, 0,             1, 32'h0,         1, 0, 0);
      add("alias_lookup",    0, 1, 32'h100,       0, 0,             0, 1, 1);
      add("neighbour_pc4",   0, 1, 32'h4,         0, 0,             0, 1, 0);
      add("low_bits_ignored",0, 1, 32'h0040_0003, 0, 0,             0, 1, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].lv, vecs[i].lpc, vecs[i].uv, vecs[i].upc, vecs[i].ut);
         check({vecs[i].name, "_valid"}, {31'd0, predict_valid}, {31'd0, vecs[i].exp_valid});
         check({vecs[i].name, "_taken"}, {31'd0, predict_taken}, {31'd0, vecs[i].exp_taken});
      end

      // X on lookup_pc with lookup_valid low must not disturb outputs or state
      drive(0, 0, 32'hxxxx_xxxx, 0, 0, 0);
      check("x_pc_valid", {31'd0, predict_valid}, 0);
      check("x_pc_taken", {31'd0, predict_taken}, 0);
      drive(0, 1, 32'h0, 0, 0, 0);
      check("x_pc_state", {31'd0, predict_taken}, 1);

      // Stats: from WNT, taken (miss), taken (hit), not-taken (miss at ST)
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 32'h30, 1);
      drive(0, 0, 0, 1, 32'h30, 1);
      drive(0, 1, 32'h30, 1, 32'h30, 0);
      check("stats_rbw_taken", {31'd0, predict_taken}, 1);
`ifdef BRANCH_PRED_STATS_EN
      exp_stats = 16'd2;
`else
      exp_stats = 16'd0;
`endif
      check("stats_count", {16'd0, mispredict_cnt}, {16'd0, exp_stats});

      // Mid-stream reset with live traffic: everything cleared, table back to WNT
      drive(0, 1, 32'h30, 0, 0, 0);
      check("pre_rst_taken", {31'd0, predict_taken}, 1);
      drive(1, 1, 32'h30, 1, 32'h30, 1);
      check("rst_valid", {31'd0, predict_valid}, 0);
      check("rst_taken", {31'd0, predict_taken}, 0);
      check("rst_stats", {16'd0, mispredict_cnt}, 0);
      drive(0, 1, 32'h30, 0, 0, 0);
      check("post_rst_0x30", {30'd0, predict_valid, predict_taken}, 32'b10);
      drive(0, 1, 32'h0, 0, 0, 0);
      check("post_rst_0x0", {30'd0, predict_valid, predict_taken}, 32'b10);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
